// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC frame sequencer: FSM state encoding and error bit positions.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_SYNC   = 3'd1,
        ST_FRAME_START = 3'd2,
        ST_RUN         = 3'd3,
        ST_DROP        = 3'd4
    } seq_state_t;

    localparam int ERR_DROP          = 0;
    localparam int ERR_SYNC_MISALIGN = 1;

endpackage

// File: rtl/adc_seq_fifo.sv
// Synchronous show-ahead FIFO: head entry is presented as soon as it is written, level is registered.
module adc_seq_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             do_push;

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push & ((level != (AW+1)'(DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      level <= level + 1'b1;
            else if (!do_push && pop) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// Packs ADC samples into whole frames on an AXI4-Stream master; frames that cannot fit are dropped entirely.
// Optional MOCK_DATA_EN replaces frame data with a {frame_counter, sample index} test pattern.
module adc_frame_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  mock_mode,
    input  logic                  arm_on_sync,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  sync_in,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [31:0]           frame_counter,
    output logic [31:0]           overflow_counter,
    output logic [31:0]           err_conds,
    output logic [31:0]           sync_reg,
    output logic [2:0]            dbg_state
);

    localparam int IDXW = $clog2(FRAME_LEN);
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]   FIT_LIMIT = LW'(FIFO_DEPTH - FRAME_LEN);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(FRAME_LEN - 1);

    seq_state_t             state, state_nxt;
    logic [IDXW-1:0]        idx, idx_nxt;
    logic                   sync_q;
    logic                   rise;
    logic                   push, push_last, inc_frame, drop_frame;
    logic                   frame_fits;
    logic [LW-1:0]          level;
    logic [DATA_WIDTH-1:0]  sample_data;
    logic [DATA_WIDTH:0]    fifo_out;
    logic                   fifo_valid;
    logic [15:0]            idx16;

    assign rise       = sync_in & ~sync_q;
    // Level is taken before this cycle's pop, so admission is conservative.
    assign frame_fits = (level <= FIT_LIMIT);
    assign idx16      = 16'(idx);
    assign dbg_state  = state;

`ifdef MOCK_DATA_EN
    logic                      mock_q;
    logic                      mock_sel;
    logic [DATA_WIDTH+31:0]    pattern_wide;

    // The mode is sampled on the first sample of a frame and held for the rest of it.
    assign mock_sel     = (state == ST_FRAME_START) ? mock_mode : mock_q;
    assign pattern_wide = {{DATA_WIDTH{1'b0}}, frame_counter[15:0], idx16};
    assign sample_data  = mock_sel ? pattern_wide[DATA_WIDTH-1:0] : adc_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mock_q <= 1'b0;
        end else if (state == ST_FRAME_START && enable && adc_valid) begin
            mock_q <= mock_mode;
        end
    end
`else
    logic mock_unused;
    assign mock_unused = mock_mode;
    assign sample_data = adc_data;
`endif

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        push       = 1'b0;
        push_last  = 1'b0;
        inc_frame  = 1'b0;
        drop_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = arm_on_sync ? ST_WAIT_SYNC : ST_FRAME_START;
            end
            ST_WAIT_SYNC: begin
                if (!enable)   state_nxt = ST_IDLE;
                else if (rise) state_nxt = ST_FRAME_START;
            end
            ST_FRAME_START: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (adc_valid) begin
                    idx_nxt = IDXW'(1);
                    if (frame_fits) begin
                        push      = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        drop_frame = 1'b1;
                        state_nxt  = ST_DROP;
                    end
                end
            end
            ST_RUN, ST_DROP: begin
                if (adc_valid) begin
                    push = (state == ST_RUN);
                    if (idx == IDX_LAST) begin
                        push_last = (state == ST_RUN);
                        inc_frame = (state == ST_RUN);
                        idx_nxt   = '0;
                        state_nxt = ST_FRAME_START;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            idx              <= '0;
            sync_q           <= 1'b0;
            frame_counter    <= '0;
            overflow_counter <= '0;
            err_conds        <= '0;
            sync_reg         <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            sync_q <= sync_in;
            if (inc_frame)  frame_counter    <= frame_counter + 1'b1;
            if (drop_frame) overflow_counter <= overflow_counter + 1'b1;
            err_conds <= '0;
            err_conds[ERR_DROP]          <= drop_frame;
            err_conds[ERR_SYNC_MISALIGN] <= rise & ((state == ST_RUN) | (state == ST_DROP));
            if (rise) sync_reg <= {frame_counter[15:0], idx16};
        end
    end

    adc_seq_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data ({push_last, sample_data}),
        .out_data  (fifo_out),
        .out_valid (fifo_valid),
        .out_ready (m_tready),
        .level     (level)
    );

    assign m_tvalid = fifo_valid;
    assign m_tdata  = fifo_valid ? fifo_out[DATA_WIDTH-1:0] : '0;
    assign m_tlast  = fifo_valid & fifo_out[DATA_WIDTH];

endmodule
